vx_fifo_packer: RTL

Upstream width-upsizing stage for the team's FIFO queues. Accepts narrow beats on a valid/ready interface, packs RATIO beats into one wide word (lane 0 = first beat), and issues a single-cycle push toward the downstream queue, throttled by that queue's `full`. Short packets terminated by `in_last` produce a partial word with a lane mask. This lets narrow producers share one wide, deep queue.

---
 rtl/vx_packer_pkg.sv | 13 +
 rtl/vx_packer_timer.sv | 38 +++
 rtl/vx_fifo_packer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vx_packer_pkg.sv
// Shared helpers for the vx_fifo_packer width-upsizing stage.
package vx_packer_pkg;

  // Index width for an n-entry range, never narrower than one bit.
  function automatic int unsigned lane_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned MAX_RATIO = 64;

  typedef logic [MAX_RATIO-1:0] lane_mask_t;

endpackage

// File: rtl/vx_packer_timer.sv
// Saturating idle counter: expired_o marks the LIMIT-th consecutive run cycle.
module vx_packer_timer
  import vx_packer_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = lane_w(LIMIT);
  localparam logic [CW-1:0] TOP = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = run_i & (count_q == TOP);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i && (count_q != TOP)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vx_fifo_packer.sv
// Packs RATIO narrow beats into one wide word with a lane mask and pushes it
// to a downstream queue. Define VX_PACKER_TIMEOUT_EN to flush idle partial words.
module vx_fifo_packer
  import vx_packer_pkg::*;
#(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned OUT_W   = IN_W * RATIO,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             push,
  output logic [OUT_W-1:0] data_out,
  output logic [RATIO-1:0] mask_out,
  input  logic             full
);

  localparam int unsigned LW = lane_w(RATIO);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || OUT_W != IN_W * RATIO || TIMEOUT < 1)
  begin : g_cfg_err
    $error("vx_fifo_packer: invalid RATIO/OUT_W/TIMEOUT configuration");
  end

  logic [LW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [RATIO-1:0] acc_mask_q, acc_mask_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [RATIO-1:0] out_mask_q, out_mask_d;
  logic             out_valid_q, out_valid_d;

  logic             slot_free;
  logic             take;
  logic             complete;
  logic             flush;
  logic [OUT_W-1:0] merge_data;
  logic [RATIO-1:0] merge_mask;

  assign slot_free = ~out_valid_q | ~full;
  assign in_ready  = reset & slot_free;
  assign push      = out_valid_q & ~full;
  assign data_out  = out_q;
  assign mask_out  = out_mask_q;
  assign take      = in_valid & in_ready;
  assign complete  = take & ((cnt_q == LW'(RATIO - 1)) | in_last);

`ifdef VX_PACKER_TIMEOUT_EN
  logic idle_run;
  logic idle_expired;

  // An accepted beat always beats the timeout, so run is gated by take.
  assign idle_run = (cnt_q != '0) & ~take;
  assign flush    = idle_expired & slot_free;

  vx_packer_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run_i    (idle_run),
    .clear_i  (~idle_run),
    .expired_o(idle_expired)
  );
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    merge_data = acc_q;
    merge_mask = acc_mask_q;
    for (int unsigned l = 0; l < RATIO; l++) begin
      if (cnt_q == LW'(l)) begin
        merge_data[l*IN_W +: IN_W] = in_data;
        merge_mask[l]              = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_mask_d  = acc_mask_q;
    out_d       = out_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q & ~push;
    if (complete) begin
      out_d       = merge_data;
      out_mask_d  = merge_mask;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
      acc_mask_d  = '0;
    end else if (flush) begin
      out_d       = acc_q;
      out_mask_d  = acc_mask_q;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
      acc_mask_d  = '0;
    end else if (take) begin
      acc_d      = merge_data;
      acc_mask_d = merge_mask;
      cnt_d      = cnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_mask_q  <= '0;
      out_q       <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_mask_q  <= acc_mask_d;
      out_q       <= out_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
